// File: rtl/mips_ctrl_pkg.sv
// Shared types for the multicycle MIPS control path:
// FSM state encoding, opcode constants, ALU op codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_IEX    = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  typedef enum logic [3:0] {
    C_LW   = 4'd0,
    C_SW   = 4'd1,
    C_R    = 4'd2,
    C_BEQ  = 4'd3,
    C_BNE  = 4'd4,
    C_ADDI = 4'd5,
    C_ANDI = 4'd6,
    C_ORI  = 4'd7,
    C_SLTI = 4'd8,
    C_J    = 4'd9,
    C_ILL  = 4'd10
  } opclass_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] reg_dst;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic [2:0] imm_alu_op(opclass_e c);
    logic [2:0] r;
    r = ALU_ADD;
    unique case (c)
      C_ANDI:  r = ALU_AND;
      C_ORI:   r = ALU_OR;
      C_SLTI:  r = ALU_SLT;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/opclass_decode.sv
// Opcode to instruction-class decoder; the
// extended immediate ops are optional.
module opclass_decode
  import mips_ctrl_pkg::*;
#(
  parameter bit EXT_IMM = 1'b1
) (
  input  logic [5:0] op,
  output opclass_e   cls,
  output logic       illegal
);

  always_comb begin
    cls = C_ILL;
    unique case (op)
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_R:    cls = C_R;
      OP_BEQ:  cls = C_BEQ;
      OP_BNE:  cls = C_BNE;
      OP_ADDI: cls = C_ADDI;
      OP_ANDI: cls = EXT_IMM ? C_ANDI : C_ILL;
      OP_ORI:  cls = EXT_IMM ? C_ORI : C_ILL;
      OP_SLTI: cls = EXT_IMM ? C_SLTI : C_ILL;
      OP_J:    cls = C_J;
      default: cls = C_ILL;
    endcase
  end

  assign illegal = (cls == C_ILL);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS main control FSM with optional
// memory handshake; class is latched in DECODE.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit EXT_IMM       = 1'b1,
  parameter int ALUOP_W       = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         reg_dst,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal_op,
  output logic [3:0]         state_dbg
);

  state_e   state;
  state_e   nxt;
  opclass_e cls_q;
  opclass_e cls_d;
  logic     dec_ill;
  logic     ready;
  ctrl_t    c;

  assign ready = !MEM_HANDSHAKE || mem_ready;

  opclass_decode #(
    .EXT_IMM(EXT_IMM)
  ) u_dec (
    .op     (op),
    .cls    (cls_d),
    .illegal(dec_ill)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      cls_q <= C_ILL;
    end else begin
      state <= nxt;
      if (state == S_DECODE) cls_q <= cls_d;
    end
  end

  always_comb begin
    nxt = S_FETCH;
    unique case (state)
      S_FETCH: nxt = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (cls_d)
          C_LW, C_SW:   nxt = S_MEMADR;
          C_R:          nxt = S_REX;
          C_BEQ, C_BNE: nxt = S_BRANCH;
          C_ADDI, C_ANDI,
          C_ORI, C_SLTI: nxt = S_IEX;
          C_J:          nxt = S_JUMP;
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = (cls_q == C_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  nxt = ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  nxt = ready ? S_FETCH : S_MEMWR;
      S_REX:    nxt = S_RWB;
      S_IEX:    nxt = S_IWB;
      default:  nxt = S_FETCH;
    endcase
  end

  always_comb begin
    c = '0;
    unique case (state)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = ready;
        c.alu_src_b = 2'b01;
        c.pc_en     = ready;
      end
      S_DECODE: begin
        c.alu_src_b  = 2'b11;
        c.illegal_op = dec_ill;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_REX: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        c.reg_dst   = 2'b01;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_SUB;
        c.pc_src    = 2'b01;
        c.pc_en     = (cls_q == C_BNE) ? !zero : zero;
      end
      S_IEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = imm_alu_op(cls_q);
      end
      S_IWB: c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_src = 2'b10;
        c.pc_en  = 1'b1;
      end
      default: c = '0;
    endcase
    // reset wins over every state, including memory waits
    if (rst) c = '0;
  end

  assign pc_en      = c.pc_en;
  assign iord       = c.iord;
  assign mem_read   = c.mem_read;
  assign mem_write  = c.mem_write;
  assign ir_write   = c.ir_write;
  assign mem_to_reg = c.mem_to_reg;
  assign reg_write  = c.reg_write;
  assign alu_src_a  = c.alu_src_a;
  assign reg_dst    = c.reg_dst;
  assign alu_src_b  = c.alu_src_b;
  assign pc_src     = c.pc_src;
  assign alu_op     = ALUOP_W'(c.alu_op);
  assign illegal_op = c.illegal_op;
  assign state_dbg  = rst ? S_FETCH : state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per-instruction reference model pushes
// expected per-cycle control vectors, monitor compares.
module tb_multicycle_controller;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] reg_dst;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst1 = 1'b1;
  logic       rst2 = 1'b1;
  logic       mem_ready = 1'b0;
  logic       zero = 1'b0;
  logic [5:0] op1 = '0;
  logic [5:0] op2 = '0;

  always #5 clk = ~clk;

  logic pc_en1, iord1, mem_read1, mem_write1, ir_write1;
  logic mem_to_reg1, reg_write1, alu_src_a1, ill1;
  logic [1:0] reg_dst1, alu_src_b1, pc_src1;
  logic [2:0] alu_op1;
  logic [3:0] st1;
  logic pc_en2, iord2, mem_read2, mem_write2, ir_write2;
  logic mem_to_reg2, reg_write2, alu_src_a2, ill2;
  logic [1:0] reg_dst2, alu_src_b2, pc_src2;
  logic [2:0] alu_op2;
  logic [3:0] st2;

  multicycle_controller dut1 (
    .clk(clk), .rst(rst1), .op(op1), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en1), .iord(iord1),
    .mem_read(mem_read1), .mem_write(mem_write1),
    .ir_write(ir_write1), .mem_to_reg(mem_to_reg1),
    .reg_write(reg_write1), .alu_src_a(alu_src_a1),
    .reg_dst(reg_dst1), .alu_src_b(alu_src_b1),
    .pc_src(pc_src1), .alu_op(alu_op1),
    .illegal_op(ill1), .state_dbg(st1)
  );

  multicycle_controller #(
    .MEM_HANDSHAKE(1'b0), .EXT_IMM(1'b0), .ALUOP_W(3)
  ) dut2 (
    .clk(clk), .rst(rst2), .op(op2), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en2), .iord(iord2),
    .mem_read(mem_read2), .mem_write(mem_write2),
    .ir_write(ir_write2), .mem_to_reg(mem_to_reg2),
    .reg_write(reg_write2), .alu_src_a(alu_src_a2),
    .reg_dst(reg_dst2), .alu_src_b(alu_src_b2),
    .pc_src(pc_src2), .alu_op(alu_op2),
    .illegal_op(ill2), .state_dbg(st2)
  );

  exp_t act1, act2, e1, e2;
  assign act1 = {st1, pc_en1, iord1, mem_read1, mem_write1,
                 ir_write1, mem_to_reg1, reg_write1, alu_src_a1,
                 reg_dst1, alu_src_b1, pc_src1, alu_op1, ill1};
  assign act2 = {st2, pc_en2, iord2, mem_read2, mem_write2,
                 ir_write2, mem_to_reg2, reg_write2, alu_src_a2,
                 reg_dst2, alu_src_b2, pc_src2, alu_op2, ill2};

  exp_t q1[$];
  exp_t q2[$];
  int   total = 0;
  int   bad = 0;

  always @(negedge clk) begin
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      total++;
      if (act1 !== e1) begin
        bad++;
        $display("FAIL dut1_ctrl t=%0t got=%h want=%h",
                 $time, act1, e1);
      end
    end
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      total++;
      if (act2 !== e2) begin
        bad++;
        $display("FAIL dut2_ctrl t=%0t got=%h want=%h",
                 $time, act2, e2);
      end
    end
  end

  function automatic exp_t blank(logic [3:0] s);
    exp_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic string kind(logic [5:0] o, bit ext);
    case (o)
      6'b100011: return "lw";
      6'b101011: return "sw";
      6'b000000: return "r";
      6'b000100: return "beq";
      6'b000101: return "bne";
      6'b001000: return "addi";
      6'b001100: return ext ? "andi" : "ill";
      6'b001101: return ext ? "ori" : "ill";
      6'b001010: return ext ? "slti" : "ill";
      6'b000010: return "j";
      default:   return "ill";
    endcase
  endfunction

  // One clock of stimulus; the idle DUT is held in reset.
  task automatic cyc(bit which, bit rdy, bit z,
                     logic [5:0] o, bit r, exp_t e);
    mem_ready = rdy;
    zero = z;
    if (!which) begin
      op1 = o; rst1 = r; q1.push_back(e);
      op2 = rop(); rst2 = 1'b1; q2.push_back(blank(S_FETCH));
    end else begin
      op2 = o; rst2 = r; q2.push_back(e);
      op1 = rop(); rst1 = 1'b1; q1.push_back(blank(S_FETCH));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(bit which, logic [5:0] o, int fw,
                           int mw, bit z, bit abort);
    bit    hs;
    string k;
    exp_t  e;
    hs = !which;
    k = kind(o, !which);
    if (hs) begin
      for (int i = 0; i < fw; i++) begin
        e = blank(S_FETCH);
        e.mem_read = 1'b1;
        e.alu_src_b = 2'b01;
        cyc(which, 1'b0, rb(), rop(), 1'b0, e);
      end
    end
    e = blank(S_FETCH);
    e.mem_read = 1'b1;
    e.ir_write = 1'b1;
    e.pc_en = 1'b1;
    e.alu_src_b = 2'b01;
    cyc(which, hs, rb(), rop(), 1'b0, e);
    e = blank(S_DECODE);
    e.alu_src_b = 2'b11;
    e.ill = (k == "ill");
    cyc(which, hs & rb(), rb(), o, 1'b0, e);
    if (k == "ill") return;
    if (k == "lw" || k == "sw") begin
      e = blank(S_MEMADR);
      e.alu_src_a = 1'b1;
      e.alu_src_b = 2'b10;
      cyc(which, hs & rb(), rb(), rop(), 1'b0, e);
      e = blank(k == "lw" ? S_MEMRD : S_MEMWR);
      e.iord = 1'b1;
      e.mem_read = (k == "lw");
      e.mem_write = (k == "sw");
      if (hs) begin
        for (int i = 0; i < mw; i++)
          cyc(which, 1'b0, rb(), rop(), 1'b0, e);
      end
      if (abort) begin
        cyc(which, rb(), rb(), rop(), 1'b1, blank(S_FETCH));
        return;
      end
      cyc(which, hs, rb(), rop(), 1'b0, e);
      if (k == "lw") begin
        e = blank(S_MEMWB);
        e.mem_to_reg = 1'b1;
        e.reg_write = 1'b1;
        cyc(which, hs & rb(), rb(), rop(), 1'b0, e);
      end
    end else if (k == "r") begin
      e = blank(S_REX);
      e.alu_src_a = 1'b1;
      e.alu_op = 3'b010;
      cyc(which, hs & rb(), rb(), rop(), 1'b0, e);
      e = blank(S_RWB);
      e.reg_dst = 2'b01;
      e.reg_write = 1'b1;
      cyc(which, hs & rb(), rb(), rop(), 1'b0, e);
    end else if (k == "beq" || k == "bne") begin
      e = blank(S_BRANCH);
      e.alu_src_a = 1'b1;
      e.alu_op = 3'b001;
      e.pc_src = 2'b01;
      e.pc_en = (k == "beq") ? z : !z;
      cyc(which, hs & rb(), z, rop(), 1'b0, e);
    end else if (k == "j") begin
      e = blank(S_JUMP);
      e.pc_src = 2'b10;
      e.pc_en = 1'b1;
      cyc(which, hs & rb(), rb(), rop(), 1'b0, e);
    end else begin
      e = blank(S_IEX);
      e.alu_src_a = 1'b1;
      e.alu_src_b = 2'b10;
      e.alu_op = (k == "andi") ? 3'b011 :
                 (k == "ori")  ? 3'b100 :
                 (k == "slti") ? 3'b101 : 3'b000;
      cyc(which, hs & rb(), rb(), rop(), 1'b0, e);
      e = blank(S_IWB);
      e.reg_write = 1'b1;
      cyc(which, hs & rb(), rb(), rop(), 1'b0, e);
    end
  endtask

  logic [5:0] optab [12];

  initial begin
    optab = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h05, 6'h08,
              6'h0c, 6'h0d, 6'h0a, 6'h02, 6'h3f, 6'h00};
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, blank(S_FETCH));
    cyc(1'b0, 1'b1, 1'b1, 6'h23, 1'b1, blank(S_FETCH));
    run_instr(1'b0, 6'h23, 0, 0, 1'b0, 1'b0);
    run_instr(1'b0, 6'h04, 0, 0, 1'b1, 1'b0);
    run_instr(1'b0, 6'h04, 0, 0, 1'b0, 1'b0);
    run_instr(1'b0, 6'h05, 0, 0, 1'b1, 1'b0);
    run_instr(1'b0, 6'h05, 0, 0, 1'b0, 1'b0);
    run_instr(1'b0, 6'h08, 3, 0, 1'b0, 1'b0);
    run_instr(1'b0, 6'h3f, 0, 0, 1'b0, 1'b0);
    run_instr(1'b0, 6'h2b, 1, 2, 1'b0, 1'b1);
    run_instr(1'b0, 6'h0d, 0, 0, 1'b0, 1'b0);
    run_instr(1'b0, 6'h00, 1, 0, 1'b0, 1'b0);
    run_instr(1'b0, 6'h02, 0, 0, 1'b0, 1'b0);
    run_instr(1'b0, 6'h2b, 0, 3, 1'b0, 1'b0);
    run_instr(1'b0, 6'h23, 2, 2, 1'b0, 1'b1);
    run_instr(1'b0, 6'h23, 0, 3, 1'b0, 1'b0);
    run_instr(1'b0, 6'h0c, 0, 0, 1'b0, 1'b0);
    run_instr(1'b0, 6'h0a, 0, 0, 1'b0, 1'b0);
    for (int n = 0; n < 150; n++) begin
      int         idx;
      logic [5:0] o;
      idx = $urandom_range(0, 11);
      o = (idx == 11) ? rop() : optab[idx];
      run_instr(1'b0, o, $urandom_range(0, 3),
                $urandom_range(0, 3), rb(),
                ($urandom_range(0, 7) == 0));
    end
    cyc(1'b1, 1'b0, 1'b0, 6'h00, 1'b1, blank(S_FETCH));
    run_instr(1'b1, 6'h0c, 2, 0, 1'b0, 1'b0);
    run_instr(1'b1, 6'h23, 2, 2, 1'b0, 1'b0);
    run_instr(1'b1, 6'h2b, 1, 3, 1'b0, 1'b0);
    run_instr(1'b1, 6'h08, 0, 0, 1'b0, 1'b0);
    run_instr(1'b1, 6'h0a, 0, 0, 1'b0, 1'b0);
    run_instr(1'b1, 6'h0d, 0, 0, 1'b0, 1'b0);
    run_instr(1'b1, 6'h05, 0, 0, 1'b0, 1'b0);
    run_instr(1'b1, 6'h00, 0, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    if (q1.size() != 0 || q2.size() != 0) begin
      bad++;
      $display("FAIL drain q1=%0d q2=%0d want=0",
               q1.size(), q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
